mem_request_router: RTL

- Sits directly downstream of the per-core memory port and upstream of the memory controller.
- Takes the single held request_t that each core presents and grants one core per cycle, round-robin.
- Buffers granted requests in a request FIFO, then drives them to memory with a ready handshake.
- Memory returns responses in order, one per request. The block tracks the owning core of each outstanding request and steers every response back to that core.

---
 rtl/mem_request_router.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_request_router.sv
// Round-robin router from per-core request ports to a single in-order memory port.
// Responses are steered back to the owning core through a core-id FIFO.
package mem_request_router_pkg;
    typedef struct packed {
        logic        vld;
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
    } request_t;
endpackage

module mem_request_router
    import mem_request_router_pkg::*;
#(
    parameter int NUM_CORES       = 4,
    parameter int REQ_FIFO_DEPTH  = 4,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  request_t [NUM_CORES-1:0]             core_req,
    output logic     [NUM_CORES-1:0]             core_req_grant,
    output request_t [NUM_CORES-1:0]             core_rsp,
    output request_t                             mem_req,
    input  logic                                 mem_req_ready,
    input  request_t                             mem_rsp,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 rsp_err
);
    localparam int RRW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int RAW = $clog2(REQ_FIFO_DEPTH);
    localparam int IAW = $clog2(MAX_OUTSTANDING);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

    request_t                 req_mem_q [REQ_FIFO_DEPTH];
    logic [RAW:0]             req_wr_q, req_rd_q;
    logic [RRW-1:0]           id_mem_q [MAX_OUTSTANDING];
    logic [IAW:0]             id_wr_q, id_rd_q;
    logic [RRW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]            out_q, out_d;
    request_t [NUM_CORES-1:0] core_rsp_q, core_rsp_d;
    logic                     rsp_err_q;

    logic           req_empty, req_full, id_empty, accept;
    logic           grant_vld, req_pop, rsp_fire, rsp_spur;
    logic [RRW-1:0] winner;

    function automatic logic [RRW-1:0] wrap_idx(input logic [RRW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        return RRW'(s % NUM_CORES);
    endfunction

    assign req_empty = (req_wr_q == req_rd_q);
    assign req_full  = (req_wr_q[RAW] != req_rd_q[RAW]) &&
                       (req_wr_q[RAW-1:0] == req_rd_q[RAW-1:0]);
    assign id_empty  = (id_wr_q == id_rd_q);
    // Accept looks at pre-pop occupancy, so a full FIFO never takes a push even while popping.
    assign accept    = !reset && !req_full && (out_q < MAX_OUT);
    assign req_pop   = !req_empty && mem_req_ready;
    assign rsp_fire  = mem_rsp.vld && (out_q != '0) && !id_empty;
    assign rsp_spur  = mem_rsp.vld && (out_q == '0);

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        grant_vld      = 1'b0;
        winner         = '0;
        core_req_grant = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (accept && !grant_vld && core_req[wrap_idx(rr_ptr_q, k)].vld) begin
                grant_vld = 1'b1;
                winner    = wrap_idx(rr_ptr_q, k);
            end
        end
        if (grant_vld) core_req_grant[winner] = 1'b1;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) rr_ptr_d = (winner == RRW'(NUM_CORES - 1)) ? '0 : winner + 1'b1;

        out_d = out_q;
        case ({grant_vld, rsp_fire})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase

        core_rsp_d = '0;
        if (rsp_fire) core_rsp_d[id_mem_q[id_rd_q[IAW-1:0]]] = mem_rsp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_wr_q   <= '0;
            req_rd_q   <= '0;
            id_wr_q    <= '0;
            id_rd_q    <= '0;
            rr_ptr_q   <= '0;
            out_q      <= '0;
            core_rsp_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (grant_vld) begin
                req_wr_q <= req_wr_q + 1'b1;
                id_wr_q  <= id_wr_q + 1'b1;
            end
            if (req_pop)  req_rd_q <= req_rd_q + 1'b1;
            if (rsp_fire) id_rd_q  <= id_rd_q + 1'b1;
            rr_ptr_q   <= rr_ptr_d;
            out_q      <= out_d;
            core_rsp_q <= core_rsp_d;
            if (rsp_spur) rsp_err_q <= 1'b1;
        end
    end

    // NOTE: storage arrays carry no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (grant_vld) begin
            req_mem_q[req_wr_q[RAW-1:0]] <= core_req[winner];
            id_mem_q[id_wr_q[IAW-1:0]]   <= winner;
        end
    end

    assign mem_req     = req_empty ? '0 : req_mem_q[req_rd_q[RAW-1:0]];
    assign core_rsp    = core_rsp_q;
    assign outstanding = out_q;
    assign rsp_err     = rsp_err_q;

endmodule
